// File: rtl/irq_ctrl_if.sv
// Purpose: bundles the irq_ctrl source/mask inputs, core handshake and status outputs.
// Latency: none, wiring only.
// Backpressure: none; the core paces the controller through irq_ack/irq_eoi.
interface irq_ctrl_if #(
  parameter int NUM_IRQ = 32
);
  logic [NUM_IRQ-1:0] irq_src;
  logic [NUM_IRQ-1:0] irq_mask;
  logic               irq_ack;
  logic               irq_eoi;
  logic               irq_req;
  logic [4:0]         irq_id;
  logic               irq_take;
  logic               irq_busy;
  logic [NUM_IRQ-1:0] irq_pend;

  // Core / source side.
  modport master (
    output irq_src, irq_mask, irq_ack, irq_eoi,
    input  irq_req, irq_id, irq_take, irq_busy, irq_pend
  );

  // Controller side.
  modport slave (
    input  irq_src, irq_mask, irq_ack, irq_eoi,
    output irq_req, irq_id, irq_take, irq_busy, irq_pend
  );
endinterface

// File: rtl/irq_ctrl.sv
// Purpose: latches interrupt sources, masks them, picks the lowest pending index and runs req/ack/eoi.
// Latency: level build req 1 edge after source; IRQ_EDGE_EN build pend at edge k, req after edge k+1.
// Backpressure: one interrupt in flight; further lines wait pending until eoi returns to IDLE.
module irq_ctrl #(
  parameter int NUM_IRQ = 32
) (
  input  logic      clk,
  input  logic      res,
  irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               irq_req_q, irq_req_d;
  logic               irq_take_q, irq_take_d;
  logic               irq_busy_q, irq_busy_d;
  logic [4:0]         irq_id_q, irq_id_d;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] masked;
  logic               any;
  logic [4:0]         sel;

`ifdef IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] src_q, src_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] clr;
  logic               ack_fire;

  // Ack only counts while a request is outstanding.
  assign ack_fire = (state_q == REQ) && bus.irq_ack;

  // Rising-edge detect sets pend; ack of the frozen id clears it; a same-cycle set wins.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr[i] = ack_fire && (irq_id_q == 5'(i));
    end
    pend_d = (pend_q & ~clr) | (bus.irq_src & ~src_q);
    src_d  = bus.irq_src;
  end

  // Pending and source history storage; src_q=0 makes lines high at release count as edges.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      src_q  <= '0;
      pend_q <= '0;
    end else begin
      src_q  <= src_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
`else
  // Level mode: pending simply mirrors the sources and is never cleared by ack.
  assign pend = bus.irq_src;
`endif

  assign masked = pend & bus.irq_mask;
  assign any    = |masked;

  // Priority pick: scanning downward leaves the lowest enabled pending index.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) sel = 5'(i);
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= IDLE;
      irq_req_q  <= 1'b0;
      irq_take_q <= 1'b0;
      irq_busy_q <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      irq_req_q  <= irq_req_d;
      irq_take_q <= irq_take_d;
      irq_busy_q <= irq_busy_d;
      irq_id_q   <= irq_id_d;
    end
  end

  // Next state: ack only matters in REQ, eoi only in SERVICE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any) state_d = REQ;
      REQ:     if (bus.irq_ack) state_d = SERVICE;
      SERVICE: if (bus.irq_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values; the id is frozen through REQ and kept until the next selection.
  always_comb begin
    irq_req_d  = irq_req_q;
    irq_take_d = 1'b0;
    irq_busy_d = irq_busy_q;
    irq_id_d   = irq_id_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          irq_req_d = 1'b1;
          irq_id_d  = sel;
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          irq_req_d  = 1'b0;
          irq_take_d = 1'b1;
          irq_busy_d = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.irq_eoi) irq_busy_d = 1'b0;
      end
      default: begin
        irq_req_d  = 1'b0;
        irq_busy_d = 1'b0;
      end
    endcase
  end

  assign bus.irq_req  = irq_req_q;
  assign bus.irq_take = irq_take_q;
  assign bus.irq_busy = irq_busy_q;
  assign bus.irq_id   = irq_id_q;
  assign bus.irq_pend = pend;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: reference model checked every cycle plus directed literal checks.
// Covers level mode by default and edge mode when IRQ_EDGE_EN is defined.
// Inputs change 2 time units after a rising edge; the model steps on the rising edge.
module tb_irq_ctrl;

  localparam int N = 32;
`ifdef IRQ_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  irq_ctrl_if #(.NUM_IRQ(N)) bus ();

  irq_ctrl #(.NUM_IRQ(N)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference model: request/service flags plus a pending set, stepped per rising edge.
  logic        m_req  = 1'b0;
  logic        m_take = 1'b0;
  logic        m_busy = 1'b0;
  int          m_id   = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_srcq = '0;

  always @(posedge clk or posedge res) begin : model
    logic [31:0] cur;
    logic [31:0] nxt;
    int          pick;
    int          cleared;
    logic        nreq;
    logic        nbusy;
    logic        ntake;
    int          nid;
    if (res) begin
      m_req  <= 1'b0;
      m_take <= 1'b0;
      m_busy <= 1'b0;
      m_id   <= 0;
      m_pend <= '0;
      m_srcq <= '0;
    end else begin
      cur = EDGE ? m_pend : bus.irq_src;
      pick = -1;
      for (int i = N - 1; i >= 0; i--) begin
        if (cur[i] && bus.irq_mask[i]) pick = i;
      end
      nreq = m_req;
      nbusy = m_busy;
      ntake = 1'b0;
      nid = m_id;
      cleared = -1;
      if (!m_req && !m_busy) begin
        if (pick >= 0) begin
          nreq = 1'b1;
          nid = pick;
        end
      end else if (m_req) begin
        if (bus.irq_ack) begin
          nreq = 1'b0;
          ntake = 1'b1;
          nbusy = 1'b1;
          cleared = m_id;
        end
      end else if (bus.irq_eoi) begin
        nbusy = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        nxt[i] = (m_pend[i] && (i != cleared)) || (bus.irq_src[i] && !m_srcq[i]);
      end
      m_req  <= nreq;
      m_busy <= nbusy;
      m_take <= ntake;
      m_id   <= nid;
      m_pend <= nxt;
      m_srcq <= bus.irq_src;
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (!res) begin
      chk("cyc_req",  32'(bus.irq_req),  32'(m_req));
      chk("cyc_take", 32'(bus.irq_take), 32'(m_take));
      chk("cyc_busy", 32'(bus.irq_busy), 32'(m_busy));
      chk("cyc_id",   32'(bus.irq_id),   32'(m_id));
      chk("cyc_pend", bus.irq_pend, EDGE ? m_pend : bus.irq_src);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    res = 1'b1;
    bus.irq_src  = '0;
    bus.irq_mask = '1;
    bus.irq_ack  = 1'b0;
    bus.irq_eoi  = 1'b0;
    #1;
    chk("rst_req",  32'(bus.irq_req), 0);
    chk("rst_take", 32'(bus.irq_take), 0);
    chk("rst_busy", 32'(bus.irq_busy), 0);
    chk("rst_id",   32'(bus.irq_id), 0);
    chk("rst_pend", bus.irq_pend, 0);
    @(posedge clk);
    tick();
    res = 1'b0;

`ifdef IRQ_EDGE_EN
    // Single pulse on line 7.
    bus.irq_src = 32'h1 << 7; tick();
    chk("e1_pend", bus.irq_pend, 32'h80);
    chk("e1_noreq", 32'(bus.irq_req), 0);
    bus.irq_src = '0; tick();
    chk("e1_req", 32'(bus.irq_req), 1);
    chk("e1_id", 32'(bus.irq_id), 7);
    bus.irq_ack = 1'b1; tick();
    chk("e1_take", 32'(bus.irq_take), 1);
    chk("e1_clr", bus.irq_pend, 0);
    bus.irq_ack = 1'b0; tick();
    chk("e1_take_off", 32'(bus.irq_take), 0);
    bus.irq_eoi = 1'b1; tick();
    chk("e1_idle", 32'(bus.irq_busy), 0);
    bus.irq_eoi = 1'b0; tick();
    // Lines 3 and 12 together.
    bus.irq_src = (32'h1 << 3) | (32'h1 << 12); tick();
    bus.irq_src = '0; tick();
    chk("e2_id3", 32'(bus.irq_id), 3);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_eoi = 1'b1; tick();
    chk("e2_left", bus.irq_pend, 32'h1000);
    bus.irq_eoi = 1'b0; tick();
    chk("e2_req12", 32'(bus.irq_req), 1);
    chk("e2_id12", 32'(bus.irq_id), 12);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_eoi = 1'b1; tick();
    bus.irq_eoi = 1'b0;
    // Masked line 5.
    bus.irq_mask = ~(32'h1 << 5); bus.irq_src = 32'h1 << 5; tick();
    bus.irq_src = '0; tick();
    chk("e3_noreq", 32'(bus.irq_req), 0);
    chk("e3_pend", bus.irq_pend, 32'h20);
`else
    // Level line 7.
    bus.irq_src = 32'h1 << 7; tick();
    chk("l1_req", 32'(bus.irq_req), 1);
    chk("l1_id", 32'(bus.irq_id), 7);
    chk("l1_pend", bus.irq_pend, 32'h80);
    bus.irq_ack = 1'b1; tick();
    chk("l1_take", 32'(bus.irq_take), 1);
    chk("l1_busy", 32'(bus.irq_busy), 1);
    bus.irq_ack = 1'b0; bus.irq_src = '0; tick();
    chk("l1_take_off", 32'(bus.irq_take), 0);
    bus.irq_eoi = 1'b1; tick();
    chk("l1_idle", 32'(bus.irq_busy), 0);
    bus.irq_eoi = 1'b0; tick();
    chk("l1_noreq", 32'(bus.irq_req), 0);
    // Lines 3 and 12 together.
    bus.irq_src = (32'h1 << 3) | (32'h1 << 12); tick();
    chk("l2_id3", 32'(bus.irq_id), 3);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_src = 32'h1 << 12; bus.irq_eoi = 1'b1; tick();
    chk("l2_gap", 32'(bus.irq_req), 0);
    bus.irq_eoi = 1'b0; tick();
    chk("l2_req12", 32'(bus.irq_req), 1);
    chk("l2_id12", 32'(bus.irq_id), 12);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_src = '0; bus.irq_eoi = 1'b1; tick();
    bus.irq_eoi = 1'b0; tick();
    // Masked line 5.
    bus.irq_mask = ~(32'h1 << 5); bus.irq_src = 32'h1 << 5; tick();
    tick();
    chk("l3_noreq", 32'(bus.irq_req), 0);
    chk("l3_pend", bus.irq_pend, 32'h20);
    bus.irq_src = '0;
`endif
    // Unmask line 5, then mask it again while requested.
    bus.irq_mask = '1;
`ifndef IRQ_EDGE_EN
    bus.irq_src = 32'h1 << 5;
`endif
    tick();
    chk("m_req5", 32'(bus.irq_req), 1);
    chk("m_id5", 32'(bus.irq_id), 5);
    bus.irq_mask = ~(32'h1 << 5); tick();
    chk("m_hold", 32'(bus.irq_req), 1);
    bus.irq_ack = 1'b1; bus.irq_eoi = 1'b1; tick();
    chk("m_take", 32'(bus.irq_take), 1);
    bus.irq_ack = 1'b0; bus.irq_eoi = 1'b0; bus.irq_mask = '1; bus.irq_src = '0; tick();
    chk("m_eoi_dropped", 32'(bus.irq_busy), 1);
    bus.irq_eoi = 1'b1; tick();
    chk("m_done", 32'(bus.irq_busy), 0);
    bus.irq_eoi = 1'b0; tick();

`ifdef IRQ_EDGE_EN
    // Set/clear collision on line 2.
    bus.irq_src = 32'h1 << 2; tick();
    bus.irq_src = '0; tick();
    chk("c_id2", 32'(bus.irq_id), 2);
    bus.irq_ack = 1'b1; bus.irq_src = 32'h1 << 2; tick();
    chk("c_take", 32'(bus.irq_take), 1);
    chk("c_pend", bus.irq_pend, 32'h4);
    bus.irq_ack = 1'b0; bus.irq_src = '0; bus.irq_eoi = 1'b1; tick();
    bus.irq_eoi = 1'b0; tick();
    chk("c_rereq", 32'(bus.irq_req), 1);
    chk("c_reid", 32'(bus.irq_id), 2);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_eoi = 1'b1; tick();
    bus.irq_eoi = 1'b0; tick();
`endif

    // Ack in IDLE is ignored.
    bus.irq_ack = 1'b1; tick();
    chk("p_ack_idle_take", 32'(bus.irq_take), 0);
    chk("p_ack_idle_busy", 32'(bus.irq_busy), 0);
    bus.irq_ack = 1'b0; bus.irq_src = 32'h1 << 9; tick();
`ifdef IRQ_EDGE_EN
    bus.irq_src = '0; tick();
`endif
    chk("p_id9", 32'(bus.irq_id), 9);
    bus.irq_eoi = 1'b1; tick();
    chk("p_eoi_req", 32'(bus.irq_req), 1);
    chk("p_eoi_busy", 32'(bus.irq_busy), 0);
    bus.irq_eoi = 1'b0; bus.irq_ack = 1'b1; tick();
    chk("p_svc", 32'(bus.irq_busy), 1);
    bus.irq_ack = 1'b0;
`ifdef IRQ_EDGE_EN
    bus.irq_src = 32'h1 << 20; tick();
    bus.irq_src = '0;
    chk("p_pend20", bus.irq_pend, 32'h100000);
`else
    bus.irq_src = '0;
`endif
    // Asynchronous reset in SERVICE.
    #1 res = 1'b1;
    #1;
    chk("ar_req",  32'(bus.irq_req), 0);
    chk("ar_take", 32'(bus.irq_take), 0);
    chk("ar_busy", 32'(bus.irq_busy), 0);
    chk("ar_id",   32'(bus.irq_id), 0);
    chk("ar_pend", bus.irq_pend, 0);
    tick();
    res = 1'b0;
    tick();
    chk("ar_lost", 32'(bus.irq_req), 0);

`ifndef IRQ_EDGE_EN
    // Level source held through eoi is re-requested; dropped before eoi it is not.
    bus.irq_src = 32'h1 << 1; tick();
    chk("h_id1", 32'(bus.irq_id), 1);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_eoi = 1'b1; tick();
    chk("h_eoi", 32'(bus.irq_busy), 0);
    bus.irq_eoi = 1'b0; tick();
    chk("h_rereq", 32'(bus.irq_req), 1);
    chk("h_reid", 32'(bus.irq_id), 1);
    bus.irq_ack = 1'b1; tick();
    bus.irq_ack = 1'b0; bus.irq_src = '0; bus.irq_eoi = 1'b1; tick();
    bus.irq_eoi = 1'b0; tick();
    chk("h_idle_req", 32'(bus.irq_req), 0);
    chk("h_idle_busy", 32'(bus.irq_busy), 0);
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
